// File: rtl/mux_stream_pkg.sv
// Shared types and constants for the N:1 packet stream multiplexer.
package mux_stream_pkg;
  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;
  localparam int ARB_SEL = 0;
  localparam int ARB_RR  = 1;
endpackage

// File: rtl/mux_stream_n1_rr_arbiter.sv
// Round-robin arbiter: the search starts just above the last granted channel
// and wraps around, so every requester is served within CHANNELS grants.
module rr_arbiter #(
  parameter  int CHANNELS = 4,
  localparam int IDX_W    = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] req,
  input  logic                update,
  output logic [CHANNELS-1:0] grant,
  output logic [IDX_W-1:0]    idx
);
  logic [IDX_W-1:0]    last_q;
  logic [CHANNELS-1:0] mask, masked, pick;
  logic                found;

  always_comb begin
    mask = '0;
    for (int i = 0; i < CHANNELS; i++) mask[i] = (i > int'(last_q));
    masked = req & mask;
    // Nothing requesting above the pointer: wrap to the lowest requester.
    pick  = (|masked) ? masked : req;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!found && pick[i]) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        idx      = IDX_W'(i);
      end
    end
  end

  // Pointer resets to the top channel so channel 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_q <= IDX_W'(CHANNELS - 1);
    else if (update) last_q <= idx;
  end
endmodule

// File: rtl/mux_stream_n1.sv
// N:1 packet stream mux: locks onto one channel for a whole packet and
// forwards it through a single registered output stage.
module mux_stream_n1
  import mux_stream_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  parameter  int ARB      = ARB_SEL,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS-1:0]       in_last,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  output logic                      out_last,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          cur_ch,
  output logic                      busy
);
  state_t           state_q, state_d;
  logic [SEL_W-1:0] cur_q, cur_d, cand_idx;
  logic             cand_vld, grant_en, slot_rdy, load;
  logic [WIDTH-1:0] odata_q;
  logic             olast_q, ovalid_q;

  assign grant_en = (state_q == IDLE) && cand_vld;

  generate
    if (ARB == ARB_RR) begin : g_rr
      logic [CHANNELS-1:0] grant;
      logic                sel_unused;
      rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (in_valid),
        .update (grant_en),
        .grant  (grant),
        .idx    (cand_idx)
      );
      assign cand_vld   = |grant;
      assign sel_unused = ^sel;
    end else begin : g_sel
      // Out-of-range selects never produce a candidate.
      always_comb begin
        cand_vld = 1'b0;
        if (int'(sel) < CHANNELS) cand_vld = in_valid[sel];
      end
      assign cand_idx = sel;
    end
  endgenerate

  assign slot_rdy = !ovalid_q || out_ready;

  always_comb begin
    in_ready = '0;
    load     = 1'b0;
    if (state_q == LOCKED) begin
      in_ready[cur_q] = slot_rdy;
      load            = in_valid[cur_q] && slot_rdy;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    case (state_q)
      IDLE: if (cand_vld) begin
        state_d = LOCKED;
        cur_d   = cand_idx;
      end
      LOCKED: if (load && in_last[cur_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
    end
  end

  // Output slot: a load overrides a drain, so back-to-back beats have no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovalid_q <= 1'b0;
      odata_q  <= '0;
      olast_q  <= 1'b0;
    end else if (load) begin
      ovalid_q <= 1'b1;
      odata_q  <= in_data[int'(cur_q)*WIDTH +: WIDTH];
      olast_q  <= in_last[cur_q];
    end else if (out_ready) begin
      ovalid_q <= 1'b0;
    end
  end

  assign out_data  = odata_q;
  assign out_last  = olast_q;
  assign out_valid = ovalid_q;
  assign cur_ch    = cur_q;
  assign busy      = (state_q == LOCKED);
endmodule

// File: doc/mux_stream_n1.md
# mux_stream_n1

Parametrised N:1 stream multiplexer, the registered, handshaked successor to the team's combinational 2:1 mux. It selects one of CHANNELS valid/ready input streams and forwards whole packets, delimited by `last`, to a single registered output. The channel is chosen either by an external select or by an internal round-robin arbiter. It sits between multiple packet producers and one shared consumer.

## Interface
- WIDTH, 8: data width per channel.
- CHANNELS, 4: number of input channels, minimum 2.
- ARB, 0: 0 = external `sel` chooses the channel; 1 = round-robin.
- SEL_W (localparam): $clog2(CHANNELS).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- sel  in  SEL_W  requested channel, used only when ARB=0 and only in IDLE.
- in_data  in  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
- in_valid  in  CHANNELS  per-channel beat valid.
- in_last  in  CHANNELS  per-channel end-of-packet marker.
- in_ready  out  CHANNELS  per-channel ready; at most one bit is high.
- out_data  out  WIDTH  registered output beat.
- out_valid  out  1  output beat valid.
- out_last  out  1  output end-of-packet marker.
- out_ready  in  1  consumer ready.
- cur_ch  out  SEL_W  currently or last granted channel.
- busy  out  1  high while in LOCKED.

## Operation
- FSM has two states.
  - IDLE: pick a candidate channel.
    - ARB=0: candidate is `sel` if sel < CHANNELS and in_valid[sel] = 1.
    - ARB=1: candidate is the first valid channel after the last granted one, wrapping at CHANNELS-1.
    - If a candidate exists, the next edge registers the grant into cur_ch and moves the FSM to LOCKED.
  - LOCKED: in_ready[cur_ch] = !out_valid || out_ready. All other in_ready bits are 0.
    - A beat transfers when in_valid[cur_ch] && in_ready[cur_ch]. It loads out_data and out_last.
    - A transferred beat with in_last=1 returns the FSM to IDLE on the same edge.
- In IDLE, all in_ready bits are 0.
- Output register behaviour:
  - out_valid is set on a load.
  - out_valid is cleared on out_ready && !load.
  - A load and an out_ready in the same cycle pass through with no bubble.
  - While out_valid && !out_ready, out_data and out_last hold stable.
- Changes on `sel` during LOCKED are ignored. There is no mid-packet switching.
- Sources must hold in_valid and in_data until they see in_ready. out_valid never drops without a handshake.

## Timing
- Reset values: out_valid=0, out_data=0, out_last=0, in_ready=0, cur_ch=0, busy=0, state=IDLE. The RR pointer resets to CHANNELS-1, so channel 0 wins first.
- Latency: the first beat appears on out 2 cycles after in_valid rises in IDLE (1 cycle grant, 1 cycle output register).
- Throughput within a packet: 1 beat per cycle. There is exactly 1 idle cycle on in_ready between packets (the IDLE arbitration cycle).
- Boundary cases:
  - Single-beat packet (first beat has last=1): grant, one transfer, back to IDLE.
  - sel >= CHANNELS: no grant, remain in IDLE.
  - No valid channel in IDLE: remain in IDLE, and cur_ch holds its value.
  - Reset asserted mid-packet: all outputs clear immediately, with no wait for clk. Any in-flight beat is dropped. The RR pointer resets.
  - out_ready held low: the FSM stays in LOCKED. in_ready[cur_ch] is 0 once out_valid=1. No beat is lost or duplicated.

## Structure
- Package mux_stream_pkg holds:
  - typedef state_t {IDLE, LOCKED}.
  - constants ARB_SEL=0 and ARB_RR=1.
- Sub-module rr_arbiter (parameter CHANNELS):
  - Inputs: req vector, update strobe.
  - Outputs: one-hot grant and encoded index.
  - Internally holds the last-granted pointer and does masked priority selection.
  - Instantiated only when ARB=1, via a generate block.

## Test plan
- ARB=0, sel=2, ch2 sends 0xA1, 0xA2, 0xA3 (last), out_ready=1 -> out shows 0xA1/0xA2/0xA3 on cycles 2, 3, 4 after valid. cur_ch=2, out_last=1 on 0xA3, busy=0 the following cycle.
- ARB=0, sel switches 2->1 mid-packet while ch1 is valid -> ch2 packet completes unbroken. ch1 is granted only after the IDLE cycle that follows 0xA3.
- Backpressure: out_ready=0 for 3 cycles mid-packet -> out_data is frozen, in_ready[cur_ch]=0, and the output sequence afterwards is identical with no gaps or duplicates.
- ARB=1, CHANNELS=4, all channels continuously valid with single-beat packets -> grant order 0, 1, 2, 3, 0, 1.
- ARB=0, CHANNELS=4, sel=5 (SEL_W widened in bench) or sel pointing at an invalid channel -> in_ready stays 0 and busy=0 indefinitely.
- rst_n pulsed low mid-packet -> out_valid, in_ready and busy drop to 0 immediately. After release with ARB=1 and all channels valid, ch0 is granted first.
